sha256d_sweep_ctrl: RTL
=======================

# sha256d_sweep_ctrl

Parametrised successor to the byte-serial SHA256d front end. It loads a block header from the host over an IO_W-wide rq/rdy handshake into a local word buffer and serves the `sha256d_wrapper` word requests from that buffer. In sweep mode it also iterates the nonce word, checks each double-hash against a leading-zero difficulty and streams back the winning nonce and hash. It sits between the TT pin mux and `sha256d_wrapper`, and replaces the fixed 8-bit, single-shot controller.

## Interface

**Parameters**

- `IO_W`, default 8: host data width. Legal values are 8, 16 and 32.
- `HDR_WORDS`, default 20: header length in 32-bit words. Range 1..32.
- `NONCE_IDX`, default 19: buffer word that holds the nonce. Must be < HDR_WORDS.
- `ZBITS`, default 16: number of leading zero bits required for `found`. Range 1..255.

**Ports.** One clock; reset is asynchronous and active-low.

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin an operation. Sampled only in IDLE.
- `mode` in 1: sampled with `start`. 0 = single hash, 1 = nonce sweep.
- `abort` in 1: end a sweep early.
- `host_data` in IO_W: host write data.
- `host_rdy` in 1: host strobe for the current transfer.
- `host_rq` out 1: block requests a transfer.
- `out_data` out IO_W: current output chunk.
- `done` out 1: result streaming in progress.
- `found` out 1: the last result met the difficulty.
- `s_start` out 1: one-cycle start pulse to the wrapper.
- `s_rdy` out 1: one-cycle "s_data valid" pulse to the wrapper.
- `s_data` out 32: word answered to the wrapper.
- `s_addr` in 5: word index requested by the wrapper.
- `s_rq` in 1: wrapper word request.
- `s_hash` in 256: wrapper digest.
- `s_done` in 1: digest valid.

## Operation

**States:** IDLE, LOAD, HASH, CHECK, OUT.

**IDLE**
- If `start`=1: latch `mode`, clear `found`, clear chunk counter `k`, go to LOAD.

**LOAD**
- Receives CH = HDR_WORDS*32/IO_W chunks. Packing is big-endian: the first chunk fills the MSBs of word 0.
- On the last transfer, latch `nonce0` = buffer[NONCE_IDX]. Pulse `s_start` and go to HASH.

**HASH**
- Wrapper service: `s_rq`=1 and `s_rdy`=0 → next edge drive `s_data`=buf[`s_addr`] and `s_rdy`=1.
- `s_addr` ≥ HDR_WORDS returns 0.
- `s_rdy` is forced to 0 the cycle after it was 1, so there is a minimum one-cycle gap between answers.
- `s_done` → latch `s_hash` into `hreg` and go to CHECK.

**CHECK** (one cycle)
- `hit` = (`hreg`[255 -: ZBITS] == 0).
- mode 0: `found`=`hit`, go to OUT.
- mode 1, `hit`: `found`=1, go to OUT.
- mode 1, (nonce+1) mod 2^32 == `nonce0` (full space exhausted): `found`=0, go to OUT.
- mode 1, otherwise: nonce ← nonce+1 (32-bit wrap, so FFFFFFFF→0 continues), pulse `s_start`, go to HASH.

**abort**
- Honoured in HASH or CHECK when mode=1: go to OUT with `found`=0, reporting the current nonce and the last `hreg`.
- Ignored in IDLE, LOAD and OUT, and in mode 0.
- `abort` wins over a simultaneous `s_done` or `hit`.

**OUT**
- `done`=1. The output stream is chunked MSB-first:
  - mode 1: {nonce, `hreg`}, 288 bits.
  - mode 0: `hreg` only, 256 bits.
- `out_data` = current chunk, combinational from `k`.
- After the last transfer: `done`←0, `k`←0, go to IDLE.

**Host handshake** (LOAD and OUT)
- `host_rq` rises one cycle after entering the state or after the previous transfer.
- A transfer happens on an edge with `host_rq`=1 and `host_rdy`=1. Data is captured, or `k` advanced, on that edge, and `host_rq` drops on the same edge.
- Minimum 2 cycles per chunk.
- `host_rdy` while `host_rq`=0 is ignored.

## Timing

- **Reset values:** all outputs 0, state IDLE, `k`=0. Buffer, `hreg` and nonce are not reset; a host must reload after reset.
- **Reset mid-operation:** immediate return to IDLE. Any `s_start`/`s_rdy` in flight is cleared. The wrapper is reset by the same `rst_n`.
- `start` → first `host_rq` = 2 cycles.
- Last LOAD transfer → `s_start` high on the next cycle, for exactly one cycle.
- Wrapper request → `s_rdy` = 1 cycle.
- `s_done` → CHECK → next `s_start` (sweep) = 2 cycles.
- `found` stays valid from CHECK until the next accepted `start`.
- `start` asserted outside IDLE is ignored.

## Test plan

- **Mode 0, IO_W=8.** Load the 80-byte header "abc"-padding vector; answer `s_rq` requests. Expect the hash stream equal to the golden SHA256d, 32 chunks, and `done` dropping after the last chunk.
- **IO_W=32, HDR_WORDS=20.** Load 20 words. Expect `s_data` to return the exact words for addr 0..19, and 0 for addr 25.
- **Sweep, ZBITS=8.** Use a wrapper model that returns a hit on the 3rd hash, start nonce 0x00000010. Expect 3 `s_start` pulses, `found`=1, and the stream to begin with 0x00000012.
- **Wrap.** Sweep with `nonce0`=0xFFFFFFFE and a hit on nonce 0x00000000. Expect 3 hashes, `found`=1, reported nonce 0.
- **Abort.** Assert `abort` in the same cycle as `s_done` of a hit. Expect `found`=0, the current nonce reported, and no further `s_start`.
- **Reset mid-LOAD after 5 chunks.** Expect all outputs 0 the next cycle. A new `start` requires the full CH chunks again.

Source files
------------

// File: rtl/sha256d_sweep_ctrl.sv
// Header loader / word server / nonce sweeper in front of sha256d_wrapper.
// Latency: start->first host_rq 2 cycles; wrapper word request answered next cycle; s_done->next s_start 2 cycles.
// Backpressure: host side is rq/rdy (transfer only when both high); wrapper answers are spaced by at least one idle cycle.
module sha256d_sweep_ctrl #(
  parameter int IO_W      = 8,
  parameter int HDR_WORDS = 20,
  parameter int NONCE_IDX = 19,
  parameter int ZBITS     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  input  logic            abort,
  input  logic [IO_W-1:0] host_data,
  input  logic            host_rdy,
  output logic            host_rq,
  output logic [IO_W-1:0] out_data,
  output logic            done,
  output logic            found,
  output logic            s_start,
  output logic            s_rdy,
  output logic [31:0]     s_data,
  input  logic [4:0]      s_addr,
  input  logic            s_rq,
  input  logic [255:0]    s_hash,
  input  logic            s_done
);

  // Chunk geometry: CPW host chunks per 32-bit word, CH chunks per header.
  localparam int CPW    = 32 / IO_W;
  localparam int CPW_LG = $clog2(CPW);
  localparam int CH     = HDR_WORDS * CPW;
  localparam int OCH1   = 288 / IO_W;
  localparam int OCH0   = 256 / IO_W;
  localparam int KW     = 8;
  localparam int WIW    = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HASH  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]    state;
  logic [KW-1:0] k;
  logic          sweep;

  // Datapath storage, intentionally not reset: a host reloads after reset.
  logic [31:0]  hdr_buf [HDR_WORDS];
  logic [31:0]  nonce;
  logic [31:0]  nonce0;
  logic [255:0] hreg;

  logic           xfer;
  logic [WIW-1:0] wi;
  logic [31:0]    hdr_cur;
  logic [31:0]    ld_word;
  logic           ld_last;
  logic [31:0]    nonce_ld;
  logic [31:0]    nonce_inc;
  logic           hit;
  logic           wrap_end;
  logic           abort_ok;
  logic           adv;
  logic [KW-1:0]  out_last_k;
  logic [287:0]   ostream;
  logic [31:0]    rd_word;

  // A transfer needs both sides: our request and the host strobe.
  assign xfer = host_rq && host_rdy;

  // Target word of the current load chunk and the word with the chunk shifted in.
  // Shifting left by IO_W per chunk leaves the first chunk in the MSBs after CPW chunks.
  assign wi      = WIW'(k >> CPW_LG);
  assign hdr_cur = hdr_buf[wi];
  assign ld_word = (hdr_cur << IO_W) | 32'(host_data);
  assign ld_last = (state == S_LOAD) && xfer && (k == KW'(CH - 1));

  // The nonce seed must include a chunk landing in the nonce word on this very edge.
  assign nonce_ld  = (wi == WIW'(NONCE_IDX)) ? ld_word : hdr_buf[NONCE_IDX];
  assign nonce_inc = nonce + 32'd1;

  // Difficulty test and sweep-termination conditions.
  assign hit      = (hreg[255 -: ZBITS] == '0);
  assign wrap_end = (nonce_inc == nonce0);
  assign abort_ok = abort && sweep;
  assign adv      = (state == S_CHECK) && sweep && !abort && !hit && !wrap_end;

  // Result stream: sweep reports the nonce ahead of the digest.
  assign ostream    = sweep ? {nonce, hreg} : {hreg, 32'h0};
  assign out_last_k = sweep ? KW'(OCH1 - 1) : KW'(OCH0 - 1);

  // Current output chunk, MSB-first, selected by k; quiet outside OUT.
  always_comb begin
    out_data = '0;
    if (state == S_OUT) begin
      out_data = IO_W'((ostream << (k * IO_W)) >> (288 - IO_W));
    end
  end

  // Word answered to the wrapper; nonce word comes from the live sweep register.
  always_comb begin
    rd_word = '0;
    if ({27'd0, s_addr} < 32'(HDR_WORDS)) begin
      if (s_addr == 5'(NONCE_IDX)) begin
        rd_word = nonce;
      end else begin
        rd_word = hdr_buf[s_addr[WIW-1:0]];
      end
    end
  end

  // Header buffer, nonce and digest capture.
  always_ff @(posedge clk) begin
    if ((state == S_LOAD) && xfer) begin
      hdr_buf[wi] <= ld_word;
    end
    if (ld_last) begin
      nonce0 <= nonce_ld;
      nonce  <= nonce_ld;
    end
    if ((state == S_HASH) && s_done && !abort_ok) begin
      hreg <= s_hash;
    end
    if (adv) begin
      nonce <= nonce_inc;
    end
  end

  // Control FSM, host handshake and wrapper pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k       <= '0;
      sweep   <= 1'b0;
      host_rq <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      s_start <= 1'b0;
      s_rdy   <= 1'b0;
      s_data  <= '0;
    end else begin
      s_start <= 1'b0;
      s_rdy   <= 1'b0;
      case (state)
        S_IDLE: begin
          host_rq <= 1'b0;
          if (start) begin
            sweep <= mode;
            found <= 1'b0;
            k     <= '0;
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (xfer) begin
            host_rq <= 1'b0;
            if (ld_last) begin
              k       <= '0;
              s_start <= 1'b1;
              state   <= S_HASH;
            end else begin
              k <= k + 1'b1;
            end
          end else begin
            host_rq <= 1'b1;
          end
        end

        S_HASH: begin
          host_rq <= 1'b0;
          // A just-answered cycle blocks the next answer, giving the mandatory gap.
          if (s_rq && !s_rdy) begin
            s_rdy  <= 1'b1;
            s_data <= rd_word;
          end
          if (abort_ok) begin
            found <= 1'b0;
            done  <= 1'b1;
            k     <= '0;
            state <= S_OUT;
          end else if (s_done) begin
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          host_rq <= 1'b0;
          if (abort_ok) begin
            found <= 1'b0;
            done  <= 1'b1;
            k     <= '0;
            state <= S_OUT;
          end else if (!sweep) begin
            found <= hit;
            done  <= 1'b1;
            k     <= '0;
            state <= S_OUT;
          end else if (hit) begin
            found <= 1'b1;
            done  <= 1'b1;
            k     <= '0;
            state <= S_OUT;
          end else if (wrap_end) begin
            found <= 1'b0;
            done  <= 1'b1;
            k     <= '0;
            state <= S_OUT;
          end else begin
            s_start <= 1'b1;
            state   <= S_HASH;
          end
        end

        S_OUT: begin
          if (xfer) begin
            host_rq <= 1'b0;
            if (k == out_last_k) begin
              done  <= 1'b0;
              k     <= '0;
              state <= S_IDLE;
            end else begin
              k <= k + 1'b1;
            end
          end else begin
            host_rq <= 1'b1;
          end
        end

        default: begin
          host_rq <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
